// File: rtl/booth_mul_ctrl.sv
// booth_mul_ctrl: radix-4 Booth multiply sequencer driving an external step datapath.
// Optional `MUL_OVF_DETECT_EN adds op_ovf, flagging a multiplier whose 2M is not representable.
module booth_mul_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic        op_clear,
  input  logic [31:0] a_multiplier,
  input  logic [31:0] a_multiplicand,
  output logic [63:0] dp_result,
  output logic [31:0] dp_multiplier,
  output logic [31:0] dp_multiplicand,
  output logic        dp_x_before,
  input  logic [63:0] dp_next_result,
  output logic        busy,
  output logic        op_done,
`ifdef MUL_OVF_DETECT_EN
  output logic        op_ovf,
`endif
  output logic [63:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic load, last;
  logic [63:0] shifted;
  always_comb begin
    load = op_start & ~op_clear & (state != RUN);
    last = (state == RUN) & (cnt == 4'd15);
    shifted = {{2{dp_next_result[63]}}, dp_next_result[63:2]};
    state_nx = op_clear ? IDLE : load ? RUN : last ? DONE : state;
    busy = (state == RUN);
    op_done = (state == DONE);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      dp_result <= '0;
      dp_multiplier <= '0;
      dp_multiplicand <= '0;
      dp_x_before <= 1'b0;
      product <= '0;
    end else begin
      state <= state_nx;
      if (op_clear) begin
        cnt <= '0;
        product <= '0;
      end else if (load) begin
        dp_result <= '0;
        dp_multiplier <= a_multiplier;
        dp_multiplicand <= a_multiplicand;
        dp_x_before <= 1'b0;
        cnt <= '0;
      end else if (busy) begin
        dp_result <= shifted;
        dp_x_before <= dp_multiplicand[1];
        dp_multiplicand <= {{2{dp_multiplicand[31]}}, dp_multiplicand[31:2]};
        cnt <= cnt + 4'd1;
        if (last) product <= shifted;
      end
    end
  end
`ifdef MUL_OVF_DETECT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) op_ovf <= 1'b0;
    else if (op_clear) op_ovf <= 1'b0;
    else if (load) op_ovf <= a_multiplier[31] ^ a_multiplier[30];
  end
`endif
endmodule
